reg27_readout: RTL

//  Read-side companion to the 27-bit enabled register bank. On request, it snapshots a

---
 rtl/reg27_readout.sv | 118 +++++++++++
 1 files changed

// File: rtl/reg27_readout.sv
// Snapshot a WIDTH-bit register word on request and stream it LSB-first as CHUNK-bit beats
// over valid/ready. Optional trailing parity beat when REG27_READOUT_PARITY_EN is defined.
module reg27_readout #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned CHUNK = 4,
    parameter int unsigned IDXW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_req,
    input  logic [WIDTH-1:0] data_in,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic [CHUNK-1:0] chunk_data,
    output logic [IDXW-1:0]  chunk_idx,
    output logic             chunk_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    // Snapshot is padded to a whole number of chunks so the final beat shifts in zeros.
    localparam int unsigned PADW   = NCHUNK * CHUNK;
`ifdef REG27_READOUT_PARITY_EN
    localparam int unsigned NBEATS = NCHUNK + 1;
`else
    localparam int unsigned NBEATS = NCHUNK;
`endif
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBEATS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [PADW-1:0] snap_q, snap_d;
    logic [IDXW-1:0] idx_q, idx_d;
`ifdef REG27_READOUT_PARITY_EN
    logic            parity_q, parity_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            snap_q   <= '0;
            idx_q    <= '0;
`ifdef REG27_READOUT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
`ifdef REG27_READOUT_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
`ifdef REG27_READOUT_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d  = StSend;
                    snap_d   = PADW'(data_in);
                    idx_d    = '0;
`ifdef REG27_READOUT_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end
            StSend: begin
                if (chunk_ready) begin
                    snap_d = snap_q >> CHUNK;
                    idx_d  = idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Beat fields are forced to zero outside SEND so idle/reset outputs read all-zero.
    always_comb begin
        chunk_valid = (state_q == StSend);
        busy        = (state_q == StSend);
        done        = (state_q == StDone);
        chunk_idx   = '0;
        chunk_data  = '0;
        chunk_last  = 1'b0;
        if (chunk_valid) begin
            chunk_idx  = idx_q;
            chunk_last = (idx_q == LAST_IDX);
            chunk_data = snap_q[CHUNK-1:0];
`ifdef REG27_READOUT_PARITY_EN
            if (idx_q == IDXW'(NCHUNK)) begin
                chunk_data = CHUNK'(parity_q);
            end
`endif
        end
    end

endmodule
